output_port_allocator: RTL and testbench
========================================

Name: output_port_allocator

Overview:
- Per-output-port switch allocator for the NoC router. One instance per output port.
- Shares the output port between NUM_INPUTS input buffers, with round-robin fairness and wormhole packet locking held until the tail flit.
- Tracks downstream credits for the output link.
- Sits between the input-buffer/route-compute stage and the crossbar. Drives the crossbar select and send_out for its port.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports (local + N/S/E/W).
- FLIT_BUFFER_DEPTH, 4, downstream buffer depth. Initial and maximum credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived; do not override).

Ports:
- clk_noc  input  1  NoC clock.
- rst_noc_sync  input  1  Synchronous reset, active-high.
- req  input  NUM_INPUTS  Input i has a head-of-queue flit routed to this output.
- req_is_tail  input  NUM_INPUTS  Head-of-queue flit of input i is a tail flit.
- disable_mask  input  NUM_INPUTS  Turn disabled from input i to this output; quasi-static.
- credit_in  input  1  One-cycle pulse; downstream freed one buffer slot.
- grant  output  NUM_INPUTS  One-hot crossbar select / dequeue strobe for this cycle's transfer.
- send_out  output  1  A flit transfers this cycle (OR of grant).
- locked  output  1  Packet in progress (state LOCKED).
- owner  output  $clog2(NUM_INPUTS)  Index of the locked input; 0 when idle.
- credits  output  CREDIT_WIDTH  Current credit count.
- credit_err  output  1  Sticky flag: credit_in received while credits==FLIT_BUFFER_DEPTH.

Behaviour:
- Reset values:
  - State IDLE, rr_ptr=0, credits=FLIT_BUFFER_DEPTH, credit_err=0, owner=0.
  - grant, send_out and locked are 0 during reset.
- grant is combinational from the registered state plus the current req/credits (zero-cycle allocation). All state updates on the rising edge of clk_noc.
- eligible = req & ~disable_mask.
- A transfer is allowed only if credits>0. When credits==0, grant=0 and send_out=0.
- IDLE:
  - Scan eligible starting at rr_ptr, wrapping modulo NUM_INPUTS. First hit w gets grant[w]=1.
  - If req_is_tail[w] (single-flit packet): stay IDLE, rr_ptr<=(w+1)%NUM_INPUTS.
  - Otherwise: go to LOCKED, owner<=w, and rr_ptr is unchanged.
  - No eligible input: nothing changes.
- LOCKED:
  - grant[owner]=req[owner] when credits>0. disable_mask is ignored because the packet was already admitted.
  - Other inputs are never granted.
  - Transfer with req_is_tail[owner]: go to IDLE, rr_ptr<=(owner+1)%NUM_INPUTS, owner<=0.
  - A bubble (req[owner]=0) holds the lock.
- Credits:
  - next = credits + credit_in - send_out.
  - credit_in and send_out in the same cycle leave the count unchanged.
  - A credit returned in cycle t is usable at t+1.
  - credit_in at FLIT_BUFFER_DEPTH without a send: count saturates and credit_err is set. credit_err clears only on reset.
  - Underflow is impossible by construction.
- Reset asserted mid-packet: the lock is dropped and the state returns to reset values on the next edge. Upstream is reset in the same domain.

Optional Feature:
- Macro OUTPUT_ALLOC_STATS_EN.
- When defined, add these outputs:
  - flit_count (32b): increments on each send_out.
  - pkt_count (32b): increments on each tail transfer.
  - stall_count (32b): increments each cycle with eligible!=0 or (locked and req[owner]), but credits==0.
  - All three wrap at 2^32 and reset to 0.
- When undefined: these ports and registers are absent. Allocation behaviour is identical.

Decomposition:
- Shared package noc_alloc_pkg:
  - typedef alloc_state_e {IDLE, LOCKED}.
  - Function rr_pick(vec, ptr), returning index and hit.
  - Port index constants LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- One natural sub-module: credit_counter. Holds the saturating up/down counter and credit_err. Reused by the serializer shim.

Test Plan:
- After reset, credits=4. req=5'b00110, all tails → grants 00010, then 00100, then 00010 on consecutive cycles. credits reach 1 after three sends with no credit_in.
- Input 3 sends a 3-flit packet (tail on flit 3) while input 0 requests continuously → grant stays 01000 (bit 3) for 3 transfers, locked=1 throughout. Input 0 is granted the cycle after the tail.
- credits drained to 0 mid-packet → grant=0 and send_out=0. One credit_in pulse → exactly one flit sent the next cycle, credits back to 0.
- credit_in and send_out in the same cycle at credits=2 → credits stays 2. credit_in at credits=4 with no send → credits=4, credit_err=1 sticky.
- disable_mask=5'b00001, req=5'b00001 → no grant while IDLE. Same mask asserted while input 0 is LOCKED → transfer continues to the tail.
- rst_noc_sync asserted for 1 cycle during LOCKED (owner=2) → next cycle locked=0, owner=0, credits=4, rr_ptr=0. Scan with req=11111 grants input 0.

Source files
------------

// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC switch allocators.
// Round-robin pick scans a zero-padded request vector, so wrapping at RR_MAX matches wrapping at the real port count.
package noc_alloc_pkg;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_e;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = $clog2(RR_MAX);

    typedef struct packed {
        logic                hit;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] vec,
                                         input logic [RR_IDX_W-1:0] ptr);
        rr_pick_t            res;
        logic [RR_IDX_W-1:0] i;
        res = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            i = ptr + RR_IDX_W'(k);
            if (!res.hit && vec[i]) begin
                res.hit = 1'b1;
                res.idx = i;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module credit_counter #(
    parameter int DEPTH = 4,
    parameter int W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         err
);

    localparam logic [W-1:0] FULL = W'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= FULL;
            err   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == FULL) err <= 1'b1;
            else               count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port switch allocator: round-robin, wormhole lock until tail, credit tracking.
// Optional OUTPUT_ALLOC_STATS_EN adds flit/packet/stall counters. Supports NUM_INPUTS <= 16.
module output_port_allocator
    import noc_alloc_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                          clk_noc,
    input  logic                          rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]         req,
    input  logic [NUM_INPUTS-1:0]         req_is_tail,
    input  logic [NUM_INPUTS-1:0]         disable_mask,
    input  logic                          credit_in,
    output logic [NUM_INPUTS-1:0]         grant,
    output logic                          send_out,
    output logic                          locked,
    output logic [$clog2(NUM_INPUTS)-1:0] owner,
    output logic [CREDIT_WIDTH-1:0]       credits,
    output logic                          credit_err
`ifdef OUTPUT_ALLOC_STATS_EN
    ,
    output logic [31:0]                   flit_count,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   stall_count
`endif
);

    localparam int            OW   = $clog2(NUM_INPUTS);
    localparam logic [OW-1:0] LAST = OW'(NUM_INPUTS - 1);

    alloc_state_e          state;
    logic [OW-1:0]         rr_ptr;
    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] grant_c;
    rr_pick_t              pick;
    logic [OW-1:0]         pick_idx;
    logic [OW-1:0]         cur_idx;
    logic                  cur_tail;
    logic                  can_send;

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    // Zero-cycle allocation: grant comes straight from registered state and live requests.
    always_comb begin
        eligible = req & ~disable_mask;
        pick     = rr_pick(RR_MAX'(eligible), RR_IDX_W'(rr_ptr));
        pick_idx = OW'(pick.idx);
        can_send = (credits != '0) && !rst_noc_sync;
        cur_idx  = (state == LOCKED) ? owner : pick_idx;
        cur_tail = req_is_tail[cur_idx];
        grant_c  = '0;
        if (can_send) begin
            if (state == LOCKED)  grant_c[owner]    = req[owner];
            else if (pick.hit)    grant_c[pick_idx] = 1'b1;
        end
    end

    assign grant    = grant_c;
    assign send_out = |grant_c;
    assign locked   = (state == LOCKED) && !rst_noc_sync;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (send_out) begin
            if (cur_tail) begin
                state  <= IDLE;
                rr_ptr <= next_idx(cur_idx);
                owner  <= '0;
            end else if (state == IDLE) begin
                state <= LOCKED;
                owner <= pick_idx;
            end
        end
    end

    credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .W     (CREDIT_WIDTH)
    ) u_credit (
        .clk   (clk_noc),
        .rst   (rst_noc_sync),
        .inc   (credit_in),
        .dec   (send_out),
        .count (credits),
        .err   (credit_err)
    );

`ifdef OUTPUT_ALLOC_STATS_EN
    logic stall;
    assign stall = ((eligible != '0) || (state == LOCKED && req[owner])) && (credits == '0);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            flit_count  <= '0;
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (send_out)             flit_count  <= flit_count + 1'b1;
            if (send_out && cur_tail) pkt_count   <= pkt_count + 1'b1;
            if (stall)                stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench: directed vector table, reset-mid-packet sequence, then random traffic vs a reference model.
module tb_output_port_allocator;

    localparam int N = 5;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic           clk_noc = 1'b0;
    logic           rst_noc_sync;
    logic [N-1:0]   req, req_is_tail, disable_mask;
    logic           credit_in;
    logic [N-1:0]   grant;
    logic           send_out, locked, credit_err;
    logic [$clog2(N)-1:0] owner;
    logic [CW-1:0]  credits;
`ifdef OUTPUT_ALLOC_STATS_EN
    logic [31:0]    flit_count, pkt_count, stall_count;
    int unsigned    m_flits, m_pkts, m_stalls;
`endif

    always #5 clk_noc = ~clk_noc;

    output_port_allocator #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(D)) dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
        .req          (req),
        .req_is_tail  (req_is_tail),
        .disable_mask (disable_mask),
        .credit_in    (credit_in),
        .grant        (grant),
        .send_out     (send_out),
        .locked       (locked),
        .owner        (owner),
        .credits      (credits),
        .credit_err   (credit_err)
`ifdef OUTPUT_ALLOC_STATS_EN
        ,
        .flit_count   (flit_count),
        .pkt_count    (pkt_count),
        .stall_count  (stall_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: packet-level view of the port.
    bit m_locked;
    int m_owner, m_ptr, m_cred;
    bit m_err;
    logic [N-1:0] m_grant;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        logic [N-1:0] elig;
        g = '0;
        elig = req & ~disable_mask;
        if (rst_noc_sync || m_cred == 0) return g;
        if (m_locked) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (elig[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = D; m_err = 0;
`ifdef OUTPUT_ALLOC_STATS_EN
        m_flits = 0; m_pkts = 0; m_stalls = 0;
`endif
    endtask

    // Drive inputs (just after a rising edge), then compare on the falling edge.
    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N-1:0] m,
                         input logic c, input logic rs);
        req = r; req_is_tail = t; disable_mask = m; credit_in = c; rst_noc_sync = rs;
        #4;
        m_grant = model_grant();
        chk("grant", int'(grant), int'(m_grant));
        chk("send_out", int'(send_out), int'(|m_grant));
        chk("locked", int'(locked), int'(m_locked && !rs));
        chk("owner", int'(owner), m_owner);
        chk("credits", int'(credits), m_cred);
        chk("credit_err", int'(credit_err), int'(m_err));
`ifdef OUTPUT_ALLOC_STATS_EN
        chk("flit_count", int'(flit_count), int'(m_flits));
        chk("pkt_count", int'(pkt_count), int'(m_pkts));
        chk("stall_count", int'(stall_count), int'(m_stalls));
`endif
    endtask

    // Advance the model with this cycle's inputs, then cross the rising edge.
    task automatic advance();
        bit send;
        int w;
        send = |m_grant;
        w = 0;
        for (int i = 0; i < N; i++) if (m_grant[i]) w = i;
        if (rst_noc_sync) begin
            model_reset();
        end else begin
`ifdef OUTPUT_ALLOC_STATS_EN
            if (send) m_flits++;
            if (send && req_is_tail[w]) m_pkts++;
            if (m_cred == 0 && (((req & ~disable_mask) != 0) || (m_locked && req[m_owner]))) m_stalls++;
`endif
            if (send) begin
                if (req_is_tail[w]) begin
                    m_locked = 0; m_owner = 0; m_ptr = (w + 1) % N;
                end else if (!m_locked) begin
                    m_locked = 1; m_owner = w;
                end
            end
            if (credit_in && !send) begin
                if (m_cred == D) m_err = 1;
                else m_cred++;
            end else if (send && !credit_in) begin
                m_cred--;
            end
        end
        @(posedge clk_noc);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] r, t, m;
        logic         c;
        logic [N-1:0] g;
        logic         lk;
        int           cr;
        logic         err;
    } vec_t;

    vec_t tbl[26];

    initial begin
        tbl[0]  = '{5'b00110, 5'b11111, 5'b00000, 1'b0, 5'b00010, 1'b0, 4, 1'b0};
        tbl[1]  = '{5'b00110, 5'b11111, 5'b00000, 1'b0, 5'b00100, 1'b0, 3, 1'b0};
        tbl[2]  = '{5'b00110, 5'b11111, 5'b00000, 1'b0, 5'b00010, 1'b0, 2, 1'b0};
        tbl[3]  = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1, 1'b0};
        tbl[4]  = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 2, 1'b0};
        tbl[5]  = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3, 1'b0};
        tbl[6]  = '{5'b01001, 5'b00001, 5'b00000, 1'b0, 5'b01000, 1'b0, 4, 1'b0};
        tbl[7]  = '{5'b01001, 5'b00001, 5'b00000, 1'b1, 5'b01000, 1'b1, 3, 1'b0};
        tbl[8]  = '{5'b01001, 5'b01001, 5'b00000, 1'b0, 5'b01000, 1'b1, 3, 1'b0};
        tbl[9]  = '{5'b00001, 5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b0, 2, 1'b0};
        tbl[10] = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b0, 1, 1'b0};
        tbl[11] = '{5'b00010, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 0, 1'b0};
        tbl[12] = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b1, 1, 1'b0};
        tbl[13] = '{5'b00010, 5'b00010, 5'b00000, 1'b1, 5'b00000, 1'b1, 0, 1'b0};
        tbl[14] = '{5'b00010, 5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1, 1'b0};
        tbl[15] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1, 1'b0};
        tbl[16] = '{5'b00100, 5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b0, 2, 1'b0};
        tbl[17] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 2, 1'b0};
        tbl[18] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3, 1'b0};
        tbl[19] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 4, 1'b0};
        tbl[20] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 4, 1'b1};
        tbl[21] = '{5'b00001, 5'b00000, 5'b00001, 1'b0, 5'b00000, 1'b0, 4, 1'b1};
        tbl[22] = '{5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00001, 1'b0, 4, 1'b1};
        tbl[23] = '{5'b00001, 5'b00000, 5'b00001, 1'b0, 5'b00001, 1'b1, 3, 1'b1};
        tbl[24] = '{5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 2, 1'b1};
        tbl[25] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1, 1'b1};

        req = '0; req_is_tail = '0; disable_mask = '0; credit_in = 1'b0;
        rst_noc_sync = 1'b1;
        repeat (2) @(posedge clk_noc);
        #1;
        model_reset();

        // Held in reset: outputs quiet, credits full.
        apply('1, '1, '0, 1'b0, 1'b1);
        chk("rst_grant", int'(grant), 0);
        chk("rst_credits", int'(credits), D);
        advance();

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].t, tbl[i].m, tbl[i].c, 1'b0);
            chk($sformatf("tbl%0d_grant", i), int'(grant), int'(tbl[i].g));
            chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("tbl%0d_credits", i), int'(credits), tbl[i].cr);
            chk($sformatf("tbl%0d_err", i), int'(credit_err), int'(tbl[i].err));
            advance();
        end

        // Lock onto input 2, then reset mid-packet.
        apply(5'b00100, 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("lock2_grant", int'(grant), 5'b00100);
        advance();
        chk("lock2_owner", int'(owner), 2);
        chk("lock2_locked", int'(locked), 1);
        apply(5'b00100, 5'b00000, 5'b00000, 1'b0, 1'b1);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_locked", int'(locked), 0);
        advance();
        apply(5'b11111, 5'b11111, 5'b00000, 1'b0, 1'b0);
        chk("postrst_locked", int'(locked), 0);
        chk("postrst_owner", int'(owner), 0);
        chk("postrst_credits", int'(credits), D);
        chk("postrst_err", int'(credit_err), 0);
        chk("postrst_grant", int'(grant), 5'b00001);
        advance();

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] r, t, m;
            logic c, rs;
            r  = N'($urandom);
            t  = N'($urandom & $urandom);
            m  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            c  = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 299) == 0);
            apply(r, t, m, c, rs);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
